// File: rtl/caches_types_pkg.sv
// Cache-subsystem types: arbiter FSM states, requester identity, lock limit default.
package caches_types_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        I_GRANT  = 2'd1,
        D_GRANT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_req_t;

    parameter int unsigned LOCK_MAX_DEFAULT = 4;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-level types: machine word and RAM handshake state.
package cpu_types_pkg;

    parameter int unsigned WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    // FREE: idle, BUSY: in progress, ACCESS: completes this cycle, ERROR: fault (retried)
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between the icache (read-only) and the dcache (read/write).
// Ties alternate between the caches; dlock keeps the dcache granted across the words of
// one block, bounded by LOCK_MAX words while the icache is waiting.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         icache read request / address
//   iwait, iload        icache stall (low on completing cycle) / read data
//   dREN, dWEN, daddr,  dcache read / write (write wins) / address / store data /
//   dstore, dlock       block lock
//   dwait, dload        dcache stall (low on completing cycle) / read data
//   ramREN, ramWEN,     RAM strobes, address, store data
//   ramaddr, ramstore
//   ramload, ramstate   RAM read data and handshake state
//   arb_err             sticky: ERROR observed during a grant
module cache_mem_arbiter
    import cpu_types_pkg::*;
    import caches_types_pkg::*;
#(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic              dlock,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              arb_err
);

    localparam int unsigned     CntW     = $clog2(LOCK_MAX + 1);
    localparam logic [CntW-1:0] LockMaxC = CntW'(LOCK_MAX);

    arb_state_t      state_q, state_d;
    arb_req_t        last_q, last_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic [CntW-1:0] lock_inc;
    logic            arb_err_q, arb_err_d;
    logic            i_done, d_done;
    logic            d_req;
    ramstate_t       rs;

    assign rs    = ramstate_t'(ramstate);
    assign d_req = dREN | dWEN;

    // Saturating increment of the locked-word count.
    assign lock_inc = (lock_cnt_q == LockMaxC) ? lock_cnt_q : lock_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        arb_err_d  = arb_err_q;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // dlock alone is not a request; ties go to whoever was not served last.
                if (d_req && (!iREN || last_q == ICACHE)) begin
                    state_d = D_GRANT;
                end else if (iREN) begin
                    state_d = I_GRANT;
                end
            end

            I_GRANT: begin
                if (!iREN) begin
                    state_d = ARB_IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (rs == ERROR) arb_err_d = 1'b1;
                    if (rs == ACCESS) begin
                        i_done  = 1'b1;
                        last_d  = ICACHE;
                        state_d = ARB_IDLE;
                    end
                end
            end

            D_GRANT: begin
                if (!d_req) begin
                    state_d    = ARB_IDLE;
                    lock_cnt_d = '0;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (rs == ERROR) arb_err_d = 1'b1;
                    if (rs == ACCESS) begin
                        d_done = 1'b1;
                        last_d = DCACHE;
                        // Lock is honoured until LOCK_MAX words if the icache is waiting.
                        if (dlock && (lock_inc < LockMaxC || !iREN)) begin
                            lock_cnt_d = lock_inc;
                        end else begin
                            lock_cnt_d = '0;
                            state_d    = ARB_IDLE;
                        end
                    end
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ARB_IDLE;
            last_q     <= ICACHE;
            lock_cnt_q <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            arb_err_q  <= arb_err_d;
        end
    end

    assign iwait   = iREN & ~i_done;
    assign dwait   = d_req & ~d_done;
    assign iload   = ramload;
    assign dload   = ramload;
    assign arb_err = arb_err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;
    import caches_types_pkg::*;

    logic        CLK, RST;
    logic        iREN, dREN, dWEN, dlock;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.WORD_W(32), .LOCK_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dlock(dlock),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; dlock = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        next_cycle();
        next_cycle();
        RST = 1'b0;
        settle();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ren: got %b want 0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", ramWEN); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", ramaddr); end
        checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL rst_store: got %h want 0", ramstore); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", arb_err); end
        checks++; if ({iwait, dwait} !== 2'b00) begin errors++; $display("FAIL rst_wait: got %b want 00", {iwait, dwait}); end
        checks++; if (dut.state_q !== ARB_IDLE) begin errors++; $display("FAIL rst_state: got %0d want ARB_IDLE", dut.state_q); end
    endtask

    task automatic test_icache_read();
        next_cycle();
        iREN = 1; iaddr = 32'h40; ramstate = FREE;
        settle();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL ird_idle_ren: got %b want 0", ramREN); end
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL ird_idle_wait: got %b want 1", iwait); end
        next_cycle();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        settle();
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL ird_ren: got %b want 1", ramREN); end
        checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL ird_addr: got %h want 40", ramaddr); end
        checks++; if (iwait !== 1'b0) begin errors++; $display("FAIL ird_wait: got %b want 0", iwait); end
        checks++; if (iload !== 32'hDEADBEEF) begin errors++; $display("FAIL ird_load: got %h want deadbeef", iload); end
        next_cycle();
        iREN = 0; ramstate = FREE;
        settle();
        checks++; if (dut.state_q !== ARB_IDLE) begin errors++; $display("FAIL ird_after: got %0d want ARB_IDLE", dut.state_q); end
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL ird_after_ren: got %b want 0", ramREN); end
    endtask

    // last_served is ICACHE here, so the first tie goes to the dcache.
    task automatic test_tie();
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h200; dstore = 32'h1234;
        next_cycle();
        ramstate = ACCESS; ramload = 32'h0;
        settle();
        checks++; if ({ramWEN, ramREN} !== 2'b10) begin errors++; $display("FAIL tie1_strobe: got %b want 10", {ramWEN, ramREN}); end
        checks++; if (ramaddr !== 32'h200) begin errors++; $display("FAIL tie1_addr: got %h want 200", ramaddr); end
        checks++; if (ramstore !== 32'h1234) begin errors++; $display("FAIL tie1_store: got %h want 1234", ramstore); end
        checks++; if ({iwait, dwait} !== 2'b10) begin errors++; $display("FAIL tie1_wait: got %b want 10", {iwait, dwait}); end
        next_cycle();
        dWEN = 0; dREN = 1; daddr = 32'h300; ramstate = FREE;
        next_cycle();
        ramstate = ACCESS; ramload = 32'h1111_2222;
        settle();
        checks++; if ({ramWEN, ramREN} !== 2'b01) begin errors++; $display("FAIL tie2_strobe: got %b want 01", {ramWEN, ramREN}); end
        checks++; if (ramaddr !== 32'h80) begin errors++; $display("FAIL tie2_addr: got %h want 80", ramaddr); end
        checks++; if ({iwait, dwait} !== 2'b01) begin errors++; $display("FAIL tie2_wait: got %b want 01", {iwait, dwait}); end
        next_cycle();
        iREN = 0; ramstate = FREE;
        next_cycle();
        ramstate = ACCESS; ramload = 32'h3333_4444;
        settle();
        checks++; if (ramaddr !== 32'h300) begin errors++; $display("FAIL tie3_addr: got %h want 300", ramaddr); end
        checks++; if (dload !== 32'h3333_4444 || dwait !== 1'b0) begin errors++; $display("FAIL tie3_dload: got %h/%b want 33334444/0", dload, dwait); end
        next_cycle();
        dREN = 0; ramstate = FREE;
    endtask

    task automatic test_writeback();
        next_cycle();
        dWEN = 1; dlock = 1; daddr = 32'h100; dstore = 32'hA;
        next_cycle();
        iREN = 1; iaddr = 32'h44; ramstate = ACCESS;
        settle();
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h100) begin errors++; $display("FAIL wb0: got %b/%h want 1/100", ramWEN, ramaddr); end
        checks++; if ({iwait, dwait} !== 2'b10) begin errors++; $display("FAIL wb0_wait: got %b want 10", {iwait, dwait}); end
        next_cycle();
        daddr = 32'h104; dstore = 32'hB; dlock = 0;
        settle();
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h104 || ramstore !== 32'hB) begin
            errors++; $display("FAIL wb1: got %b/%h/%h want 1/104/b", ramWEN, ramaddr, ramstore);
        end
        checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL wb1_wait: got %b want 0", dwait); end
        next_cycle();
        dWEN = 0; ramstate = FREE;
        settle();
        checks++; if ({ramWEN, ramREN} !== 2'b00) begin errors++; $display("FAIL wb_idle: got %b want 00", {ramWEN, ramREN}); end
        next_cycle();
        ramstate = ACCESS; ramload = 32'h5555;
        settle();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || iwait !== 1'b0) begin
            errors++; $display("FAIL wb_igrant: got %b/%h/%b want 1/44/0", ramREN, ramaddr, iwait);
        end
        next_cycle();
        iREN = 0; ramstate = FREE;
    endtask

    // last_served is ICACHE, so the dcache wins the opening tie.
    task automatic test_lock_limit();
        next_cycle();
        dWEN = 1; dlock = 1; daddr = 32'h200; iREN = 1; iaddr = 32'h48;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            daddr = 32'h200 + 32'(4 * k); ramstate = ACCESS;
            settle();
            checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h200 + 32'(4 * k) || dwait !== 1'b0 || iwait !== 1'b1) begin
                errors++; $display("FAIL lock_word%0d: got %b/%h/%b/%b want 1/%h/0/1", k, ramWEN, ramaddr, dwait, iwait, 32'h200 + 32'(4 * k));
            end
        end
        next_cycle();
        daddr = 32'h210; ramstate = FREE;
        settle();
        checks++; if (dut.state_q !== ARB_IDLE || ramWEN !== 1'b0) begin
            errors++; $display("FAIL lock_release: got %0d/%b want ARB_IDLE/0", dut.state_q, ramWEN);
        end
        next_cycle();
        ramstate = ACCESS;
        settle();
        checks++; if ({ramWEN, ramREN} !== 2'b01 || ramaddr !== 32'h48 || {iwait, dwait} !== 2'b01) begin
            errors++; $display("FAIL lock_igrant: got %b/%h/%b want 01/48/01", {ramWEN, ramREN}, ramaddr, {iwait, dwait});
        end
        next_cycle();
        iREN = 0; ramstate = FREE;
        next_cycle();
        ramstate = ACCESS;
        settle();
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h210 || dwait !== 1'b0) begin
            errors++; $display("FAIL lock_word5: got %b/%h/%b want 1/210/0", ramWEN, ramaddr, dwait);
        end
        next_cycle();
        daddr = 32'h214; dlock = 0;
        settle();
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h214 || dwait !== 1'b0) begin
            errors++; $display("FAIL lock_word6: got %b/%h/%b want 1/214/0", ramWEN, ramaddr, dwait);
        end
        next_cycle();
        dWEN = 0; ramstate = FREE;
    endtask

    task automatic test_busy_error();
        int pulses;
        pulses = 0;
        next_cycle();
        iREN = 1; iaddr = 32'h60;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            ramstate = BUSY;
            settle();
            if (iwait === 1'b0) pulses++;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h60 || iwait !== 1'b1 || arb_err !== 1'b0) begin
                errors++; $display("FAIL busy%0d: got %b/%h/%b/%b want 1/60/1/0", k, ramREN, ramaddr, iwait, arb_err);
            end
        end
        next_cycle();
        ramstate = ERROR;
        settle();
        if (iwait === 1'b0) pulses++;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h60 || iwait !== 1'b1) begin
            errors++; $display("FAIL err_hold: got %b/%h/%b want 1/60/1", ramREN, ramaddr, iwait);
        end
        next_cycle();
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        settle();
        if (iwait === 1'b0) pulses++;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", arb_err); end
        checks++; if (ramREN !== 1'b1 || iload !== 32'hCAFEF00D) begin
            errors++; $display("FAIL err_done: got %b/%h want 1/cafef00d", ramREN, iload);
        end
        next_cycle();
        settle();
        if (iwait === 1'b0) pulses++;
        iREN = 0; ramstate = FREE;
        settle();
        checks++; if (pulses !== 1) begin errors++; $display("FAIL err_pulses: got %0d want 1", pulses); end
        next_cycle();
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", arb_err); end
    endtask

    task automatic test_reset_mid();
        dWEN = 1; daddr = 32'h500; dstore = 32'h55;
        next_cycle();
        ramstate = BUSY;
        settle();
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h500) begin
            errors++; $display("FAIL rmid_pre: got %b/%h want 1/500", ramWEN, ramaddr);
        end
        RST = 1;
        next_cycle();
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rmid_wen: got %b want 0", ramWEN); end
        checks++; if (dut.state_q !== ARB_IDLE) begin errors++; $display("FAIL rmid_state: got %0d want ARB_IDLE", dut.state_q); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", arb_err); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rmid_dwait: got %b want 1", dwait); end
        RST = 0; dWEN = 0; ramstate = FREE;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_tie();
        test_writeback();
        test_lock_limit();
        test_busy_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Registered arbiter that shares the single RAM port between the instruction cache (read-only) and the data cache (read/write).
- Sequences data-cache multi-word transactions (ALLOC fills, WB0/WB1 write-backs, DUMP flushes) atomically under a lock.
- Alternates fairly between the two caches on ties.
- Sits between icache/dcache and the RAM model; drives the RAM handshake and returns load data and wait signals to each cache.

Parameters:
- WORD_W, 32, data/address width (word_t).
- LOCK_MAX, 4, maximum consecutive dcache words held under dlock while icache waits; afterwards the lock is ignored for one arbitration.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- iREN  in  1  icache read request.
- iaddr  in  WORD_W  icache word address.
- iwait  out  1  icache stall; low for exactly the completing cycle.
- iload  out  WORD_W  icache read data, valid when iwait low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both high.
- daddr  in  WORD_W  dcache word address.
- dstore  in  WORD_W  dcache write data.
- dlock  in  1  dcache holds grant across consecutive words of one block.
- dwait  out  1  dcache stall; low for exactly the completing cycle.
- dload  out  WORD_W  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- arb_err  out  1  sticky, set when ERROR is seen during a grant.

Behaviour:
- Synchronous reset and active-high.
- Reset state: state=ARB_IDLE, last_served=ICACHE, lock_cnt=0, arb_err=0. ramREN=ramWEN=0, ramaddr=ramstore=0.
- iwait follows iREN and dwait follows (dREN|dWEN) combinationally; both are 1 whenever a request is pending and not completing.
- States:
  - ARB_IDLE. Sample requests.
    - Only D requests -> D_GRANT.
    - Only I requests -> I_GRANT.
    - Both request -> D_GRANT if last_served=ICACHE, else I_GRANT.
    - Neither -> stay.
    - The grant takes effect the next cycle; no RAM strobe in ARB_IDLE.
  - I_GRANT. ramREN=1, ramaddr=iaddr.
    - ramstate=ACCESS: iwait=0, iload=ramload, last_served<=ICACHE -> ARB_IDLE.
    - iREN dropped: strobes go low -> ARB_IDLE; no completion.
  - D_GRANT. ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
    - ACCESS: dwait=0, dload=ramload, last_served<=DCACHE, lock_cnt++.
      - If dlock=1 and (lock_cnt+1<LOCK_MAX or iREN=0): stay in D_GRANT.
      - Otherwise: -> ARB_IDLE and lock_cnt<=0.
    - Request dropped: -> ARB_IDLE and lock_cnt<=0.
- BUSY: hold all strobes, address and data; the cache keeps waiting.
- ERROR during a grant: arb_err<=1. The transaction is treated as BUSY (retried) until ACCESS or the request drops.
- Minimum latency from a request rising in ARB_IDLE to completion is 2 cycles (1 arbitration + 1 RAM ACCESS).
- A back-to-back locked dcache word completes every RAM-ACCESS cycle with no idle gap.
- dlock with no request is ignored in ARB_IDLE.
- lock_cnt saturates at LOCK_MAX; its width is clog2(LOCK_MAX+1).
- RST asserted mid-grant: state returns to ARB_IDLE at the next edge and strobes drop immediately after that edge. No partial write is retried.

Decomposition:
- Add to caches_types_pkg: arb_state_t enum {ARB_IDLE, I_GRANT, D_GRANT}, arb_req_t enum {ICACHE, DCACHE}, and the LOCK_MAX default constant.
- ramstate_t and word_t come from cpu_types_pkg.
- No sub-module. The FSM, tie-break register and lock counter are one always_ff block plus one always_comb output decoder.

Test Plan:
- Reset, iREN=1, iaddr=0x40, RAM returns ACCESS with ramload=0xDEADBEEF on the 2nd cycle -> ramREN=1 on cycle 1, iwait=0 and iload=0xDEADBEEF on the ACCESS cycle, ARB_IDLE after.
- iREN and dWEN rise together after reset -> dcache served first (ramWEN=1, ramaddr=daddr). On the next tie, icache is served.
- dcache 2-word write-back: dlock=1, dWEN to 0x100 then 0x104, icache waiting, LOCK_MAX=4 -> both words complete consecutively and I_GRANT follows.
- dlock held for 6 words with iREN=1 -> icache is granted after the 4th dcache word and the dcache resumes after the icache completes.
- ramstate BUSY for 3 cycles then ERROR then ACCESS -> strobes and address stable throughout, arb_err=1 sticky, single completion pulse.
- RST pulsed while D_GRANT ramWEN=1 -> ramWEN=0 after the edge, state ARB_IDLE, arb_err=0, and the dcache still sees dwait=1.
